// File: rtl/constraint_scan_ctrl_if.sv
// rtl/constraint_scan_ctrl_if.sv - bus bundle between solver front-end and constraint_scan_ctrl
// Purpose: groups the table-load, candidate, verdict and statistics signals.
// Signals: cfg_* (table write), start_*/cand_data (candidate offer),
//          abort, result_* / fail_idx (verdict), busy, pass_cnt/fail_cnt.
// Modports: master = solver front-end, slave = constraint_scan_ctrl.
interface constraint_scan_ctrl_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_CONS = 8,
  parameter int IDX_W    = 3
);
  logic                      cfg_we;
  logic                      cfg_ready;
  logic [IDX_W-1:0]          cfg_idx;
  logic [WIDTH-1:0]          cfg_const;
  logic                      cfg_op;
  logic                      cfg_en;
  logic                      start_valid;
  logic                      start_ready;
  logic [NUM_CONS*WIDTH-1:0] cand_data;
  logic                      abort;
  logic                      result_valid;
  logic                      result_ready;
  logic                      result_sat;
  logic [IDX_W-1:0]          fail_idx;
  logic                      busy;
  logic [15:0]               pass_cnt;
  logic [15:0]               fail_cnt;

  modport master (
    output cfg_we, cfg_idx, cfg_const, cfg_op, cfg_en,
    output start_valid, cand_data, abort, result_ready,
    input  cfg_ready, start_ready, result_valid, result_sat, fail_idx,
    input  busy, pass_cnt, fail_cnt
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_const, cfg_op, cfg_en,
    input  start_valid, cand_data, abort, result_ready,
    output cfg_ready, start_ready, result_valid, result_sat, fail_idx,
    output busy, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/constraint_scan_ctrl.sv
// rtl/constraint_scan_ctrl.sv - sequential constraint evaluator with one shared comparator
// Purpose: scans a table of NUM_CONS (const, op, en) slots against a latched
//          candidate, one slot per cycle, and returns a sat/fail verdict.
// Ports: clk, rst_n (async active-low), bus (constraint_scan_ctrl_if.slave):
//        table load (cfg_*), candidate (start_*, cand_data), abort,
//        verdict (result_*, fail_idx), busy, saturating pass/fail counters.
module constraint_scan_ctrl #(
  parameter int WIDTH      = 16,
  parameter int NUM_CONS   = 8,
  parameter int IDX_W      = 3,
  parameter int EARLY_EXIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  constraint_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q;
  logic [NUM_CONS*WIDTH-1:0] cand_q;
  logic [WIDTH-1:0]          const_q [NUM_CONS];
  logic [NUM_CONS-1:0]       op_q;
  logic [NUM_CONS-1:0]       en_q;
  logic                      fail_seen_q;
  logic [IDX_W-1:0]          first_fail_q;
  logic                      sat_q;
  logic [IDX_W-1:0]          fail_idx_q;
  logic [15:0]               pass_cnt_q;
  logic [15:0]               fail_cnt_q;

  logic [WIDTH-1:0] operand;
  logic             slot_fail;
  logic             last_slot;
  logic             verdict_fail;
  logic [IDX_W-1:0] verdict_idx;
  logic             enter_done;

  // Shared comparator: one slot evaluated per SCAN cycle.
  always_comb begin
    operand      = cand_q[idx_q*WIDTH +: WIDTH];
    slot_fail    = en_q[idx_q] &&
                   (op_q[idx_q] ? (operand != const_q[idx_q]) : (operand == const_q[idx_q]));
    last_slot    = (idx_q == IDX_W'(NUM_CONS-1));
    // An earlier recorded failure (full-scan mode) takes priority over the current slot.
    verdict_fail = slot_fail || fail_seen_q;
    verdict_idx  = fail_seen_q ? first_fail_q : idx_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort beats a verdict produced in the same SCAN cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start_valid) state_d = SCAN;
      SCAN: begin
        if (bus.abort)
          state_d = IDLE;
        else if ((slot_fail && (EARLY_EXIT != 0)) || last_slot)
          state_d = DONE;
      end
      DONE: if (bus.result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.cfg_ready    = (state_q == IDLE);
    bus.start_ready  = (state_q == IDLE);
    bus.result_valid = (state_q == DONE);
    bus.busy         = (state_q != IDLE);
    bus.result_sat   = sat_q;
    bus.fail_idx     = fail_idx_q;
    bus.pass_cnt     = pass_cnt_q;
    bus.fail_cnt     = fail_cnt_q;
  end

  assign enter_done = (state_q == SCAN) && (state_d == DONE);

  // Table, candidate latch, scan bookkeeping and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CONS; i++) const_q[i] <= '0;
      op_q         <= '0;
      en_q         <= '0;
      cand_q       <= '0;
      idx_q        <= '0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= '0;
      sat_q        <= 1'b0;
      fail_idx_q   <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
    end else begin
      // A write in the start cycle lands before slot 0 is read in the next cycle.
      if (state_q == IDLE && bus.cfg_we) begin
        const_q[bus.cfg_idx] <= bus.cfg_const;
        op_q[bus.cfg_idx]    <= bus.cfg_op;
        en_q[bus.cfg_idx]    <= bus.cfg_en;
      end
      if (state_q == IDLE && bus.start_valid) begin
        cand_q       <= bus.cand_data;
        idx_q        <= '0;
        fail_seen_q  <= 1'b0;
        first_fail_q <= '0;
      end
      if (enter_done) begin
        sat_q      <= !verdict_fail;
        fail_idx_q <= verdict_fail ? verdict_idx : '0;
        if (verdict_fail) begin
          if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
        end else begin
          if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
        end
      end else if (state_q == SCAN && !bus.abort) begin
        idx_q <= idx_q + IDX_W'(1);
        if (slot_fail && !fail_seen_q) begin
          fail_seen_q  <= 1'b1;
          first_fail_q <= idx_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_constraint_scan_ctrl.sv
// tb/tb_constraint_scan_ctrl.sv - directed self-checking bench for constraint_scan_ctrl
module tb_constraint_scan_ctrl;

  localparam int WIDTH    = 16;
  localparam int NUM_CONS = 8;
  localparam int IDX_W    = 3;
  localparam int CW       = NUM_CONS*WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  constraint_scan_ctrl_if #(.WIDTH(WIDTH), .NUM_CONS(NUM_CONS), .IDX_W(IDX_W)) bus1 ();
  constraint_scan_ctrl_if #(.WIDTH(WIDTH), .NUM_CONS(NUM_CONS), .IDX_W(IDX_W)) bus2 ();

  // Second instance (full scan) receives exactly the same stimulus.
  assign bus2.cfg_we       = bus1.cfg_we;
  assign bus2.cfg_idx      = bus1.cfg_idx;
  assign bus2.cfg_const    = bus1.cfg_const;
  assign bus2.cfg_op       = bus1.cfg_op;
  assign bus2.cfg_en       = bus1.cfg_en;
  assign bus2.start_valid  = bus1.start_valid;
  assign bus2.cand_data    = bus1.cand_data;
  assign bus2.abort        = bus1.abort;
  assign bus2.result_ready = bus1.result_ready;

  constraint_scan_ctrl #(.WIDTH(WIDTH), .NUM_CONS(NUM_CONS), .IDX_W(IDX_W), .EARLY_EXIT(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  constraint_scan_ctrl #(.WIDTH(WIDTH), .NUM_CONS(NUM_CONS), .IDX_W(IDX_W), .EARLY_EXIT(0))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus1.cfg_we = 0; bus1.cfg_idx = '0; bus1.cfg_const = '0; bus1.cfg_op = 0; bus1.cfg_en = 0;
    bus1.start_valid = 0; bus1.cand_data = '0; bus1.abort = 0; bus1.result_ready = 1;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic cfg_write(input int idx, input logic [15:0] c, input logic op, input logic en);
    bus1.cfg_we = 1; bus1.cfg_idx = IDX_W'(idx); bus1.cfg_const = c; bus1.cfg_op = op; bus1.cfg_en = en;
    @(negedge clk);
    bus1.cfg_we = 0;
  endtask

  // Called at a negedge with DUT idle; latency counted in cycles after the start cycle.
  task automatic run_scan(input logic [CW-1:0] cand, input logic exp_sat,
                          input int exp_idx, input int exp_lat, input string tag);
    int lat;
    logic found;
    lat = 0; found = 0;
    bus1.cand_data = cand; bus1.start_valid = 1;
    while (!found && lat < 40) begin
      @(negedge clk);
      bus1.start_valid = 0;
      lat++;
      if (bus1.result_valid) found = 1;
    end
    check({tag, " found"}, 32'(found), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " sat"}, 32'(bus1.result_sat), 32'(exp_sat));
    check({tag, " fail_idx"}, 32'(bus1.fail_idx), 32'(exp_idx));
    if (bus1.result_ready) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] c;
    int lat, l1, l2, seen;
    logic s1, s2;
    logic [IDX_W-1:0] f1, f2;

    // Reset state
    do_reset();
    check("rst cfg_ready", 32'(bus1.cfg_ready), 32'd1);
    check("rst start_ready", 32'(bus1.start_ready), 32'd1);
    check("rst result_valid", 32'(bus1.result_valid), 32'd0);
    check("rst busy", 32'(bus1.busy), 32'd0);
    check("rst result_sat", 32'(bus1.result_sat), 32'd0);
    check("rst fail_idx", 32'(bus1.fail_idx), 32'd0);
    check("rst pass_cnt", 32'(bus1.pass_cnt), 32'd0);
    check("rst fail_cnt", 32'(bus1.fail_cnt), 32'd0);

    // Early exit versus full scan
    do_reset();
    cfg_write(2, 16'h00FF, 1'b1, 1'b1);
    cfg_write(5, 16'h00FF, 1'b1, 1'b1);
    bus1.cand_data = {NUM_CONS{16'h00FE}};
    bus1.start_valid = 1;
    lat = 0; l1 = 0; l2 = 0; s1 = 1; s2 = 1; f1 = '0; f2 = '0;
    while ((l1 == 0 || l2 == 0) && lat < 40) begin
      @(negedge clk);
      bus1.start_valid = 0;
      lat++;
      if (l1 == 0 && bus1.result_valid) begin l1 = lat; s1 = bus1.result_sat; f1 = bus1.fail_idx; end
      if (l2 == 0 && bus2.result_valid) begin l2 = lat; s2 = bus2.result_sat; f2 = bus2.fail_idx; end
    end
    check("ee1 latency", 32'(l1), 32'd4);
    check("ee1 sat", 32'(s1), 32'd0);
    check("ee1 fail_idx", 32'(f1), 32'd2);
    check("ee0 latency", 32'(l2), 32'd9);
    check("ee0 sat", 32'(s2), 32'd0);
    check("ee0 fail_idx", 32'(f2), 32'd2);
    @(negedge clk);
    check("ee1 fail_cnt", 32'(bus1.fail_cnt), 32'd1);
    check("ee0 fail_cnt", 32'(bus2.fail_cnt), 32'd1);
    check("ee0 pass_cnt", 32'(bus2.pass_cnt), 32'd0);

    // Single NEQ slot
    do_reset();
    cfg_write(0, 16'h1BDE, 1'b0, 1'b1);
    c = '0; c[15:0] = 16'h1BDF;
    run_scan(c, 1'b1, 0, 9, "neq pass");
    c[15:0] = 16'h1BDE;
    run_scan(c, 1'b0, 0, 2, "neq fail");
    check("neq pass_cnt", 32'(bus1.pass_cnt), 32'd1);
    check("neq fail_cnt", 32'(bus1.fail_cnt), 32'd1);

    // Handshake backpressure
    do_reset();
    cfg_write(1, 16'h0042, 1'b0, 1'b1);
    bus1.result_ready = 0;
    c = '0; c[31:16] = 16'h0042;
    run_scan(c, 1'b0, 1, 3, "bp");
    for (int i = 0; i < 5; i++) begin
      bus1.cand_data = {4{$urandom()}};
      bus1.cfg_we = 1; bus1.cfg_idx = 3'd1; bus1.cfg_const = 16'h0000; bus1.cfg_en = 0;
      @(negedge clk);
      check("bp result_valid", 32'(bus1.result_valid), 32'd1);
      check("bp sat", 32'(bus1.result_sat), 32'd0);
      check("bp fail_idx", 32'(bus1.fail_idx), 32'd1);
      check("bp start_ready", 32'(bus1.start_ready), 32'd0);
      check("bp fail_cnt", 32'(bus1.fail_cnt), 32'd1);
    end
    bus1.cfg_we = 0;
    bus1.result_ready = 1;
    @(negedge clk);
    check("bp idle", 32'(bus1.busy), 32'd0);
    run_scan(c, 1'b0, 1, 3, "bp table");
    check("bp fail_cnt2", 32'(bus1.fail_cnt), 32'd2);

    // Abort in SCAN, then abort in DONE
    do_reset();
    c = {4{$urandom()}};
    bus1.cand_data = c; bus1.start_valid = 1;
    @(negedge clk);
    bus1.start_valid = 0;
    @(negedge clk);
    @(negedge clk);
    bus1.abort = 1;
    @(negedge clk);
    bus1.abort = 0;
    check("abort busy", 32'(bus1.busy), 32'd0);
    check("abort start_ready", 32'(bus1.start_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus1.result_valid) seen++;
      @(negedge clk);
    end
    check("abort no verdict", 32'(seen), 32'd0);
    check("abort pass_cnt", 32'(bus1.pass_cnt), 32'd0);
    check("abort fail_cnt", 32'(bus1.fail_cnt), 32'd0);
    bus1.result_ready = 0;
    run_scan(c, 1'b1, 0, 9, "abort done");
    bus1.abort = 1;
    repeat (2) @(negedge clk);
    check("abort done valid", 32'(bus1.result_valid), 32'd1);
    check("abort done sat", 32'(bus1.result_sat), 32'd1);
    check("abort done pass_cnt", 32'(bus1.pass_cnt), 32'd1);
    bus1.abort = 0;
    bus1.result_ready = 1;
    @(negedge clk);
    check("abort done idle", 32'(bus1.busy), 32'd0);

    // Reset mid-scan
    do_reset();
    cfg_write(0, 16'h1BDE, 1'b0, 1'b1);
    c = '0; c[15:0] = 16'h1BDE;
    bus1.cand_data = c; bus1.start_valid = 1;
    @(negedge clk);
    bus1.start_valid = 0;
    rst_n = 0;
    #1;
    check("rstscan valid", 32'(bus1.result_valid), 32'd0);
    check("rstscan busy", 32'(bus1.busy), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rstscan cfg_ready", 32'(bus1.cfg_ready), 32'd1);
    check("rstscan pass_cnt", 32'(bus1.pass_cnt), 32'd0);
    check("rstscan fail_cnt", 32'(bus1.fail_cnt), 32'd0);
    run_scan(c, 1'b1, 0, 9, "rstscan rescan");

    // Counter saturation
    do_reset();
    force dut1.pass_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut1.pass_cnt_q;
    @(negedge clk);
    c = '0;
    run_scan(c, 1'b1, 0, 9, "sat1");
    check("sat pass_cnt1", 32'(bus1.pass_cnt), 32'hFFFF);
    run_scan(c, 1'b1, 0, 9, "sat2");
    check("sat pass_cnt2", 32'(bus1.pass_cnt), 32'hFFFF);
    check("sat fail_cnt", 32'(bus1.fail_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
